// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the Hamming distance blocks.
package hamming_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} hamming_argmin_state_t;

    // Bits needed to hold any value 0..n. A distance over N bits spans 0..N.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) <= n) r++;
        return r;
    endfunction

    function automatic int hamming_dist_w(input int n);
        return log2(n);
    endfunction

endpackage

// File: rtl/hamming_min_cmp.sv
// Strict-less select between the running minimum and a new distance.
module hamming_min_cmp #(
    parameter int D_W = 4,
    parameter int I_W = 2
) (
    input  logic [D_W-1:0] cur_min,
    input  logic [I_W-1:0] cur_idx,
    input  logic [D_W-1:0] d_in,
    input  logic [I_W-1:0] idx,
    output logic [D_W-1:0] new_min,
    output logic [I_W-1:0] new_idx
);

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        new_min = cur_min;
        new_idx = cur_idx;
        if (d_in < cur_min) begin
            new_min = d_in;
            new_idx = idx;
        end
    end

endmodule

// File: rtl/hamming_argmin_nbit.sv
// Per-frame argmin over K streamed Hamming distances, with threshold match.
module hamming_argmin_nbit
    import hamming_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4,
    localparam int D_W = hamming_dist_w(N),
    localparam int I_W = log2(K - 1),
    localparam int C_W = I_W + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           d_valid,
    input  logic [D_W-1:0] d_in,
    input  logic [D_W-1:0] thresh,
    output logic           busy,
    output logic           done,
    output logic [D_W-1:0] min_dist,
    output logic [I_W-1:0] min_idx,
    output logic           match
);

    hamming_argmin_state_t state_q, state_d;
    logic [C_W-1:0] count_q, count_d;
    logic [D_W-1:0] run_min_q, run_min_d;
    logic [I_W-1:0] run_idx_q, run_idx_d;
    logic [D_W-1:0] thresh_q, thresh_d;
    logic [D_W-1:0] min_dist_q, min_dist_d;
    logic [I_W-1:0] min_idx_q, min_idx_d;
    logic           match_q, match_d;
    logic [D_W-1:0] new_min;
    logic [I_W-1:0] new_idx;
    logic           accept, last_accept, start_ok;

    hamming_min_cmp #(.D_W(D_W), .I_W(I_W)) u_cmp (
        .cur_min (run_min_q),
        .cur_idx (run_idx_q),
        .d_in    (d_in),
        .idx     (count_q[I_W-1:0]),
        .new_min (new_min),
        .new_idx (new_idx)
    );

    assign start_ok    = start && (state_q != RUN);
    assign accept      = d_valid && (state_q == RUN);
    assign last_accept = accept && (count_q == C_W'(K - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            run_min_q  <= '0;
            run_idx_q  <= '0;
            thresh_q   <= '0;
            min_dist_q <= '0;
            min_idx_q  <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            run_min_q  <= run_min_d;
            run_idx_q  <= run_idx_d;
            thresh_q   <= thresh_d;
            min_dist_q <= min_dist_d;
            min_idx_q  <= min_idx_d;
            match_q    <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (last_accept) state_d = DONE;
            DONE:    state_d = start_ok ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: frame init on start, per-accept update, result load on the K-th accept.
    always_comb begin
        count_d    = count_q;
        run_min_d  = run_min_q;
        run_idx_d  = run_idx_q;
        thresh_d   = thresh_q;
        min_dist_d = min_dist_q;
        min_idx_d  = min_idx_q;
        match_d    = match_q;
        if (start_ok) begin
            count_d   = '0;
            run_min_d = '1;
            run_idx_d = '0;
            thresh_d  = thresh;
        end else if (accept) begin
            count_d   = count_q + C_W'(1);
            run_min_d = new_min;
            run_idx_d = new_idx;
            if (last_accept) begin
                min_dist_d = new_min;
                min_idx_d  = new_idx;
                match_d    = (new_min <= thresh_q);
            end
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        min_dist = min_dist_q;
        min_idx  = min_idx_q;
        match    = match_q;
    end

endmodule

// File: tb/tb_hamming_argmin_nbit.sv
// Randomized and directed checks of hamming_argmin_nbit against a frame-level model.
module tb_hamming_argmin_nbit;
    localparam int N = 8;
    localparam int K = 4;
    localparam int D_W = 4;
    localparam int I_W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           d_valid = 1'b0;
    logic [D_W-1:0] d_in = '0;
    logic [D_W-1:0] thresh = '0;
    logic           busy, done, match;
    logic [D_W-1:0] min_dist;
    logic [I_W-1:0] min_idx;

    int errors = 0;
    int checks = 0;
    int fv[K];
    int fg[K];
    bit busy_bad, done_early;
    int em, ei, emt;
    int pm, pi, pmt;

    hamming_argmin_nbit #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .d_valid(d_valid), .d_in(d_in),
        .thresh(thresh), .busy(busy), .done(done), .min_dist(min_dist),
        .min_idx(min_idx), .match(match)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame model: smallest value, earliest position on ties, compared to threshold.
    task automatic ref_frame(input int th, output int m, output int ix, output int mt);
        m = fv[0];
        ix = 0;
        for (int i = 1; i < K; i++) if (fv[i] < m) begin m = fv[i]; ix = i; end
        mt = (m <= th) ? 1 : 0;
    endtask

    // Drives a frame; extra_at >= 0 raises start alongside that accept.
    task automatic do_frame(input int th, input int extra_at);
        start = 1'b1; thresh = D_W'(th);
        tick;
        start = 1'b0; thresh = D_W'($urandom);
        busy_bad = 0; done_early = 0;
        for (int i = 0; i < K; i++) begin
            for (int g = 0; g < fg[i]; g++) begin
                d_valid = 1'b0; d_in = D_W'($urandom);
                tick;
                if (busy !== 1'b1) busy_bad = 1;
                if (done !== 1'b0) done_early = 1;
            end
            d_valid = 1'b1; d_in = D_W'(fv[i]);
            if (i == extra_at) start = 1'b1;
            tick;
            start = 1'b0; d_valid = 1'b0; d_in = D_W'($urandom);
            if (i < K - 1) begin
                if (busy !== 1'b1) busy_bad = 1;
                if (done !== 1'b0) done_early = 1;
            end
        end
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d);
        fv[0] = a; fv[1] = b; fv[2] = c; fv[3] = d;
        for (int i = 0; i < K; i++) fg[i] = 0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++; if ({busy, done, match} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {busy, done, match}); end
        checks++; if (min_dist !== 0 || min_idx !== 0) begin errors++; $display("FAIL reset_outs got=%0d/%0d want=0/0", min_dist, min_idx); end
        tick; rst = 1'b1; tick;
    endtask

    task automatic test_basic;
        set_frame(4, 5, 0, 3);
        ref_frame(3, em, ei, emt);
        do_frame(3, -1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got=%b%b want=10", done, busy); end
        checks++; if (min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL basic_result got=%0d/%0d/%b want=%0d/%0d/%0d", min_dist, min_idx, match, em, ei, emt); end
        checks++; if (busy_bad || done_early) begin errors++; $display("FAIL basic_flags got=%b%b want=00", busy_bad, done_early); end
        tick;
        checks++; if (done !== 1'b0 || min_dist !== em) begin errors++; $display("FAIL basic_pulse got=%b/%0d want=0/%0d", done, min_dist, em); end
    endtask

    task automatic test_tie;
        set_frame(3, 2, 2, 7);
        ref_frame(1, em, ei, emt);
        do_frame(1, -1);
        checks++; if (done !== 1'b1 || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL tie got=%b %0d/%0d/%b want=1 %0d/%0d/%0d", done, min_dist, min_idx, match, em, ei, emt); end
        tick;
    endtask

    task automatic test_stalls;
        set_frame(6, 1, 4, 1);
        fg[1] = 2; fg[2] = 5;
        ref_frame(0, em, ei, emt);
        do_frame(0, -1);
        checks++; if (busy_bad || done_early) begin errors++; $display("FAIL stall_busy got=%b%b want=00", busy_bad, done_early); end
        checks++; if (done !== 1'b1 || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL stall_result got=%b %0d/%0d/%b want=1 %0d/%0d/%0d", done, min_dist, min_idx, match, em, ei, emt); end
        tick;
    endtask

    task automatic test_start_in_run;
        pm = em; pi = ei; pmt = emt;
        set_frame(7, 5, 6, 2);
        ref_frame(2, em, ei, emt);
        start = 1'b1; thresh = 4'd2;
        tick;
        start = 1'b0;
        for (int i = 0; i < K; i++) begin
            d_valid = 1'b1; d_in = D_W'(fv[i]);
            start = (i == 2);
            thresh = 4'd15;
            tick;
            start = 1'b0; d_valid = 1'b0;
            if (i < K - 1) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1 || min_dist !== pm || min_idx !== pi) begin errors++; $display("FAIL run_hold%0d got=%b%b %0d/%0d want=01 %0d/%0d", i, done, busy, min_dist, min_idx, pm, pi); end
            end
        end
        checks++; if (done !== 1'b1 || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL run_extra got=%b %0d/%0d/%b want=1 %0d/%0d/%0d", done, min_dist, min_idx, match, em, ei, emt); end
        tick;
    endtask

    task automatic test_reset_mid;
        bit seen;
        start = 1'b1; thresh = 4'd4;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin d_valid = 1'b1; d_in = 4'd0; tick; end
        d_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, done, match} !== 3'b000 || min_dist !== 0 || min_idx !== 0) begin errors++; $display("FAIL mid_reset got=%b%b%b %0d/%0d want=000 0/0", busy, done, match, min_dist, min_idx); end
        tick; rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin d_valid = 1'b1; tick; if (done) seen = 1; end
        d_valid = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL mid_nodone got=1 want=0"); end
        set_frame(3, 3, 3, 3);
        ref_frame(4, em, ei, emt);
        do_frame(4, -1);
        checks++; if (done !== 1'b1 || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL mid_after got=%b %0d/%0d/%b want=1 %0d/%0d/%0d", done, min_dist, min_idx, match, em, ei, emt); end
        tick;
    endtask

    task automatic test_idle_dvalid;
        start = 1'b1; d_valid = 1'b1; d_in = 4'd0; thresh = 4'd5;
        tick;
        start = 1'b0;
        for (int i = 0; i < K; i++) begin d_valid = 1'b1; d_in = 4'd5; tick; end
        d_valid = 1'b0;
        checks++; if (done !== 1'b1 || min_dist !== 5 || min_idx !== 0 || match !== 1'b1) begin errors++; $display("FAIL idle_dv got=%b %0d/%0d/%b want=1 5/0/1", done, min_dist, min_idx, match); end
        tick;
    endtask

    task automatic test_back_to_back;
        set_frame(2, 1, 6, 1);
        ref_frame(1, em, ei, emt);
        do_frame(1, -1);
        pm = em; pi = ei; pmt = emt;
        checks++; if (done !== 1'b1 || min_dist !== pm || min_idx !== pi) begin errors++; $display("FAIL b2b_first got=%b %0d/%0d want=1 %0d/%0d", done, min_dist, min_idx, pm, pi); end
        set_frame(8, 8, 8, 8);
        ref_frame(7, em, ei, emt);
        do_frame(7, -1);
        checks++; if (busy_bad || done_early) begin errors++; $display("FAIL b2b_flags got=%b%b want=00", busy_bad, done_early); end
        checks++; if (done !== 1'b1 || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL b2b_second got=%b %0d/%0d/%b want=1 %0d/%0d/%0d", done, min_dist, min_idx, match, em, ei, emt); end
        tick;
    endtask

    task automatic test_hold_between;
        set_frame(5, 6, 7, 8);
        ref_frame(4, em, ei, emt);
        do_frame(4, -1);
        pm = em; pi = ei;
        tick;
        start = 1'b1; thresh = 4'd0;
        tick;
        start = 1'b0;
        d_valid = 1'b1; d_in = 4'd0; tick; d_valid = 1'b0;
        checks++; if (min_dist !== pm || min_idx !== pi || match !== 1'b0) begin errors++; $display("FAIL hold got=%0d/%0d/%b want=%0d/%0d/0", min_dist, min_idx, match, pm, pi); end
        for (int i = 0; i < K - 1; i++) begin d_valid = 1'b1; d_in = 4'd8; tick; end
        d_valid = 1'b0;
        checks++; if (done !== 1'b1 || min_dist !== 0 || match !== 1'b1) begin errors++; $display("FAIL hold_end got=%b %0d/%b want=1 0/1", done, min_dist, match); end
        tick;
    endtask

    task automatic test_random;
        int th;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < K; i++) begin
                fv[i] = $urandom_range(0, N);
                fg[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            th = $urandom_range(0, N);
            ref_frame(th, em, ei, emt);
            do_frame(th, ($urandom_range(0, 3) == 0) ? $urandom_range(0, K - 2) : -1);
            checks++; if (done !== 1'b1 || busy_bad || done_early || min_dist !== em || min_idx !== ei || match !== emt[0]) begin errors++; $display("FAIL rand%0d got=%b%b%b %0d/%0d/%b want=100 %0d/%0d/%0d", f, done, busy_bad, done_early, min_dist, min_idx, match, em, ei, emt); end
            if ($urandom_range(0, 1) == 1) tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_tie;
        test_stalls;
        test_start_in_run;
        test_reset_mid;
        test_idle_dvalid;
        test_back_to_back;
        test_hold_between;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
